// File: rtl/register_dump_pkg.sv
// Shared constants for register_dump: FSM state encoding, header byte, word/byte ratio.
package register_dump_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_SET_ADDR = 3'd1;
    localparam logic [STATE_W-1:0] ST_LATCH    = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND     = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT_TX  = 3'd4;
    localparam logic [STATE_W-1:0] ST_NEXT     = 3'd5;
    localparam logic [STATE_W-1:0] ST_FINISH   = 3'd6;
    localparam logic [STATE_W-1:0] ST_HEADER   = 3'd7;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam int unsigned DEFAULT_BYTES_PER_WORD = 32 / 8;

    function automatic int unsigned bytes_per_word(input int unsigned nb, input int unsigned nb_byte);
        return nb / nb_byte;
    endfunction

endpackage

// File: rtl/register_dump.sv
// Streams the whole register file, little-endian, one byte per transmitter handshake.
// Optional leading 8'hA5 header byte when REG_DUMP_HEADER_EN is defined.
module register_dump
    import register_dump_pkg::*;
#(
    parameter int NB      = 32,
    parameter int REGS    = 5,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [REGS-1:0]    o_mips_register_number,
    input  logic [NB-1:0]      i_mips_register_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned BPW   = bytes_per_word(NB, NB_BYTE);
    localparam int unsigned CNT_W = $clog2(BPW + 1);

`ifdef REG_DUMP_HEADER_EN
    localparam logic HEADER_EN = 1'b1;
`else
    localparam logic HEADER_EN = 1'b0;
`endif

    logic [STATE_W-1:0] state;
    logic [NB-1:0]      buffer;
    logic [CNT_W-1:0]   byte_cnt;
    logic [REGS-1:0]    reg_num;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_start;
    logic               hdr_active;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            buffer     <= '0;
            byte_cnt   <= '0;
            reg_num    <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            hdr_active <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= HEADER_EN ? ST_HEADER : ST_SET_ADDR;
                    end
                end
                ST_HEADER: begin
                    tx_data    <= NB_BYTE'(HEADER_BYTE);
                    tx_start   <= 1'b1;
                    hdr_active <= 1'b1;
                    state      <= ST_WAIT_TX;
                end
                // Address is already on the port; this cycle lets a registered read settle.
                ST_SET_ADDR: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    buffer   <= i_mips_register_data;
                    byte_cnt <= CNT_W'(BPW);
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    tx_data  <= buffer[NB_BYTE-1:0];
                    tx_start <= 1'b1;
                    state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (hdr_active) begin
                            hdr_active <= 1'b0;
                            state      <= ST_SET_ADDR;
                        end else begin
                            buffer   <= buffer >> NB_BYTE;
                            byte_cnt <= byte_cnt - CNT_W'(1);
                            state    <= (byte_cnt == CNT_W'(1)) ? ST_NEXT : ST_SEND;
                        end
                    end
                end
                // Wrap of the register number back to 0 marks the end of the dump.
                ST_NEXT: begin
                    reg_num <= reg_num + REGS'(1);
                    state   <= (reg_num == '1) ? ST_FINISH : ST_SET_ADDR;
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_busy = (state != ST_IDLE) && (state != ST_FINISH);
        o_done = (state == ST_FINISH);
    end

    assign o_mips_register_number = reg_num;
    assign o_tx_data              = tx_data;
    assign o_tx_start             = tx_start;

endmodule
